// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder with bit-slip symbol alignment
//
// Ports:
//   clk_in      pixel clock, one raw word per cycle
//   rst_in      synchronous active-low reset
//   tmds_in     raw deserialized 10-bit word, bit 0 earliest on the wire
//   data_out    decoded pixel byte (0 for tokens or when unlocked)
//   control_out decoded control bits {C1,C0} (0 for data or when unlocked)
//   ve_out      1 = data symbol, 0 = control token or unlocked
//   locked_out  1 = symbol alignment locked
//   offset_out  current bit offset into the two-word window, 0..9
module tmds_decoder #(
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int MAX_GAP       = 2048
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       locked_out,
    output logic [3:0] offset_out
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int TMR_W = $clog2(SEARCH_WINDOW);
    localparam int GAP_W = $clog2(MAX_GAP);

    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SEARCH_WINDOW - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [9:0]       r_prev;
    logic [9:0]       r_sym;
    logic [3:0]       r_offset;
    logic [RUN_W-1:0] r_tok_run;
    logic [TMR_W-1:0] r_timer;
    logic [GAP_W-1:0] r_gap;
    logic [7:0]       r_data;
    logic [1:0]       r_ctrl;
    logic             r_ve;
    logic             r_locked;

    logic [19:0]      w_window;
    logic [9:0]       w_sym;
    logic             w_is_tok;
    logic [1:0]       w_tok_bits;
    logic [8:0]       w_q;
    logic [7:0]       w_d;

    // The previous word sits in the low half so that window bit 0 is the
    // earliest bit on the wire; offset n skips the first n bits.
    assign w_window = {tmds_in, r_prev};
    assign w_sym    = 10'(w_window >> r_offset);

    always_comb begin
        w_is_tok   = 1'b0;
        w_tok_bits = 2'b00;
        case (r_sym)
            10'b1101010100: begin w_is_tok = 1'b1; w_tok_bits = 2'b00; end
            10'b0010101011: begin w_is_tok = 1'b1; w_tok_bits = 2'b01; end
            10'b0101010100: begin w_is_tok = 1'b1; w_tok_bits = 2'b10; end
            10'b1010101011: begin w_is_tok = 1'b1; w_tok_bits = 2'b11; end
            default:        begin w_is_tok = 1'b0; w_tok_bits = 2'b00; end
        endcase
    end

    // Undo the DC-balance inversion (bit 9), then the XOR/XNOR chain (bit 8).
    always_comb begin
        w_q    = r_sym[9] ? {r_sym[8], ~r_sym[7:0]} : r_sym[8:0];
        w_d    = 8'h00;
        w_d[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            w_d[i] = w_q[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state   <= S_SEARCH;
            r_prev    <= '0;
            r_sym     <= '0;
            r_offset  <= '0;
            r_tok_run <= '0;
            r_timer   <= '0;
            r_gap     <= '0;
            r_data    <= '0;
            r_ctrl    <= '0;
            r_ve      <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_prev   <= tmds_in;
            r_sym    <= w_sym;
            r_locked <= (r_state == S_LOCKED);

            // Output stage is gated by the same state that drives locked_out,
            // so ve/control/data and locked_out switch together.
            if (r_state == S_LOCKED) begin
                if (w_is_tok) begin
                    r_ve   <= 1'b0;
                    r_ctrl <= w_tok_bits;
                    r_data <= 8'h00;
                end else begin
                    r_ve   <= 1'b1;
                    r_ctrl <= 2'b00;
                    r_data <= w_d;
                end
            end else begin
                r_ve   <= 1'b0;
                r_ctrl <= 2'b00;
                r_data <= 8'h00;
            end

            case (r_state)
                S_SEARCH: begin
                    // Lock is checked before timer expiry so it wins a tie.
                    if (w_is_tok && (r_tok_run == RUN_LAST)) begin
                        r_state   <= S_LOCKED;
                        r_tok_run <= RUN_FULL;
                        r_gap     <= '0;
                    end else if (r_timer == TMR_LAST) begin
                        r_offset  <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                        r_timer   <= '0;
                        r_tok_run <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                        if (!w_is_tok) begin
                            r_tok_run <= '0;
                        end else if (r_tok_run != RUN_FULL) begin
                            r_tok_run <= r_tok_run + RUN_W'(1);
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_is_tok) begin
                        r_gap <= '0;
                    end else if (r_gap == GAP_LAST) begin
                        r_state   <= S_SEARCH;
                        r_timer   <= '0;
                        r_tok_run <= '0;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= S_SEARCH;
            endcase
        end
    end

    assign data_out    = r_data;
    assign control_out = r_ctrl;
    assign ve_out      = r_ve;
    assign locked_out  = r_locked;
    assign offset_out  = r_offset;

endmodule
